// File: rtl/frame_rr_mux_if.sv
// Ingress/egress packet-FIFO bundle for frame_rr_mux.
// master: the multiplexer (reads N ingress FIFOs, writes one egress FIFO).
// slave:  the FIFO side (ingress FIFOs plus the egress FIFO).
interface frame_rr_mux_if #(
    parameter int N_CH = 3,
    parameter int DW   = 8
);
    logic [N_CH-1:0]    in_empty;
    logic [N_CH*DW-1:0] in_dout;
    logic [N_CH-1:0]    in_eod;
    logic [N_CH-1:0]    in_rden;
    logic               out_afull;
    logic [DW-1:0]      out_din;
    logic               out_wren;
    logic               out_eod;

    modport master (
        input  in_empty, in_dout, in_eod, out_afull,
        output in_rden, out_din, out_wren, out_eod
    );

    modport slave (
        output in_empty, in_dout, in_eod, out_afull,
        input  in_rden, out_din, out_wren, out_eod
    );
endinterface

// File: rtl/frame_rr_mux.sv
// N-channel frame multiplexer: drains whole frames from per-port ingress
// FIFOs (registered read, one read in flight) into a single egress FIFO.
// Round-robin arbitration at frame granularity, inter-frame gap, frame
// length limit with truncation (excess bytes drained and dropped).
module frame_rr_mux #(
    parameter int N_CH    = 3,     // 2..8
    parameter int DW      = 8,
    parameter int IFG_CYC = 12,    // >= 1
    parameter int MAX_LEN = 1522   // >= 2
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [N_CH-1:0]    ch_en,
    frame_rr_mux_if.master     bus,
    output logic [N_CH-1:0]    grant,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         trunc_cnt
);

    localparam int CW = $clog2(N_CH);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = (IFG_CYC > 1) ? $clog2(IFG_CYC + 1) : 1;

    // DRAIN is split in two so that only one read is ever outstanding:
    // DRAIN_RD issues the read, DRAIN_CHK looks at the returned EOD.
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DRAIN_RD,
        DRAIN_CHK,
        GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   ptr;      // last channel served
    logic [CW-1:0]   gidx;     // owning channel index
    logic [LW-1:0]   len;      // bytes written in the current frame
    logic [GW-1:0]   gap_cnt;

    logic            found;
    logic [CW-1:0]   pick;
    logic [DW-1:0]   cur_dout;
    logic            cur_eod;
    logic            cur_empty;
    logic            last_allowed;

    logic [N_CH-1:0] rden;
    logic [DW-1:0]   din;
    logic            wren;
    logic            eod;

    // Round-robin search starting at ptr+1, wrapping modulo N_CH.
    always_comb begin
        logic [CW:0] sum;
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it unassigned (no latch).
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            sum = {1'b0, ptr} + (CW+1)'(k);
            if (sum >= (CW+1)'(N_CH))
                sum = sum - (CW+1)'(N_CH);
            if (!found && ch_en[sum[CW-1:0]] && !bus.in_empty[sum[CW-1:0]]) begin
                found = 1'b1;
                pick  = sum[CW-1:0];
            end
        end
    end

    // Select the owning channel's FIFO signals.
    always_comb begin
        cur_dout  = '0;
        cur_eod   = 1'b0;
        cur_empty = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (gidx == CW'(i)) begin
                cur_dout  = bus.in_dout[i*DW +: DW];
                cur_eod   = bus.in_eod[i];
                cur_empty = bus.in_empty[i];
            end
        end
    end

    assign last_allowed = (len == LW'(MAX_LEN - 1));

    // FIFO strobes and egress data decoded from state and inputs.
    always_comb begin
        rden = '0;
        din  = '0;
        wren = 1'b0;
        eod  = 1'b0;
        case (state)
            RD: begin
                if (!cur_empty && !bus.out_afull)
                    rden[gidx] = 1'b1;
            end
            WR: begin
                wren = 1'b1;
                din  = cur_dout;
                eod  = cur_eod | last_allowed;
            end
            DRAIN_RD: begin
                if (!cur_empty)
                    rden[gidx] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_rden  = rden;
    assign bus.out_din  = din;
    assign bus.out_wren = wren;
    assign bus.out_eod  = eod;
    assign busy         = (state != IDLE);

    // Frame state machine, grant/pointer bookkeeping and counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            ptr       <= CW'(N_CH - 1);
            gidx      <= '0;
            grant     <= '0;
            len       <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            trunc_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values, independent of block order.
            case (state)
                IDLE: begin
                    if (found) begin
                        gidx  <= pick;
                        grant <= N_CH'(1) << pick;
                        len   <= '0;
                        state <= RD;
                    end
                end
                RD: begin
                    if (!cur_empty && !bus.out_afull)
                        state <= WR;
                end
                WR: begin
                    len <= len + LW'(1);
                    if (cur_eod) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (last_allowed) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (trunc_cnt != 8'hFF)
                            trunc_cnt <= trunc_cnt + 8'd1;
                        state <= DRAIN_RD;
                    end else begin
                        state <= RD;
                    end
                end
                DRAIN_RD: begin
                    if (!cur_empty)
                        state <= DRAIN_CHK;
                end
                DRAIN_CHK: begin
                    if (cur_eod) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        state <= DRAIN_RD;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(IFG_CYC - 1)) begin
                        ptr   <= gidx;
                        grant <= '0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rr_mux.sv
// Self-checking bench for frame_rr_mux: ingress FIFO models, per-channel
// expected-byte scoreboard, round-robin reference, directed and random tests.
module tb_frame_rr_mux;

    localparam int N_CH    = 3;
    localparam int DW      = 8;
    localparam int IFG_CYC = 12;
    localparam int MAX_LEN = 16;
    localparam int DEPTH   = 4096;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] grant;
    logic            busy;
    logic [15:0]     frame_cnt;
    logic [7:0]      trunc_cnt;

    frame_rr_mux_if #(.N_CH(N_CH), .DW(DW)) bus ();

    frame_rr_mux #(
        .N_CH(N_CH), .DW(DW), .IFG_CYC(IFG_CYC), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .ch_en(ch_en),
        .bus(bus.master),
        .grant(grant),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ingress FIFO models (registered read) ----------------
    logic [DW:0] mem [N_CH][DEPTH];   // {eod, data}
    int          wr_ptr [N_CH];
    int          rd_ptr [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            bus.in_empty[i] = (rd_ptr[i] == wr_ptr[i]);
    end

    // The ingress FIFOs share the reset: contents are flushed.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N_CH; i++)
                rd_ptr[i] <= wr_ptr[i];
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.in_rden[i]) begin
                    rd_ptr[i]               <= rd_ptr[i] + 1;
                    bus.in_dout[i*DW +: DW] <= mem[i][rd_ptr[i] % DEPTH][DW-1:0];
                    bus.in_eod[i]           <= mem[i][rd_ptr[i] % DEPTH][DW];
                end
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [DW:0] exp_q [N_CH][$];
    int          exp_frames = 0;
    int          exp_trunc  = 0;
    int          grant_log [$];

    // Push a frame into channel ch and the bytes the egress must see.
    task automatic push_frame(input int ch, input int len);
        logic [DW-1:0] d;
        logic          e;
        for (int b = 0; b < len; b++) begin
            d = DW'($urandom);
            e = (b == len - 1);
            mem[ch][(wr_ptr[ch] + b) % DEPTH] = {e, d};
            if (b < MAX_LEN)
                exp_q[ch].push_back({e || (b == MAX_LEN - 1), d});
        end
        wr_ptr[ch] = wr_ptr[ch] + len;
        exp_frames++;
        if (len > MAX_LEN)
            exp_trunc++;
    endtask

    function automatic logic [N_CH-1:0] rr_pick(input int p, input logic [N_CH-1:0] req);
        for (int k = 1; k <= N_CH; k++)
            if (req[(p + k) % N_CH])
                return N_CH'(1) << ((p + k) % N_CH);
        return '0;
    endfunction

    function automatic int oh2idx(input logic [N_CH-1:0] v);
        for (int i = 0; i < N_CH; i++)
            if (v[i])
                return i;
        return 0;
    endfunction

    // Monitor: compares every egress write and every new grant.
    int              mon_cyc = 0;
    int              ptr_m = N_CH - 1;
    int              last_eod_cyc = -1;
    logic [N_CH-1:0] req_prev = '0;
    logic [N_CH-1:0] grant_prev = '0;

    always @(negedge clk) begin
        if (!arst_n) begin
            ptr_m        = N_CH - 1;
            last_eod_cyc = -1;
            req_prev     = '0;
            grant_prev   = '0;
            for (int i = 0; i < N_CH; i++)
                exp_q[i].delete();
        end else begin
            mon_cyc++;
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("rden_onehot0", 32'($onehot0(bus.in_rden)), 32'd1);
            if (bus.in_rden != '0)
                check("rden_on_grant", 32'(bus.in_rden), 32'(grant));
            if (grant != '0 && grant_prev == '0) begin
                check("rr_grant", 32'(grant), 32'(rr_pick(ptr_m, req_prev)));
                grant_log.push_back(oh2idx(grant));
                if (last_eod_cyc >= 0)
                    check("ifg_min", 32'(mon_cyc - last_eod_cyc >= IFG_CYC + 2), 32'd1);
            end
            if (grant == '0 && grant_prev != '0)
                ptr_m = oh2idx(grant_prev);
            if (bus.out_wren) begin
                int ch;
                ch = oh2idx(grant);
                check("wren_has_grant", 32'(grant != '0), 32'd1);
                if (exp_q[ch].size() == 0) begin
                    check("unexpected_write", 32'({bus.out_eod, bus.out_din}), 32'h1_0000);
                end else begin
                    logic [DW:0] e;
                    e = exp_q[ch].pop_front();
                    check("out_byte", 32'({bus.out_eod, bus.out_din}), 32'(e));
                end
                if (bus.out_eod)
                    last_eod_cyc = mon_cyc;
            end
            req_prev   = ch_en & ~bus.in_empty;
            grant_prev = grant;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit all_done();
        for (int i = 0; i < N_CH; i++)
            if (exp_q[i].size() != 0 || rd_ptr[i] != wr_ptr[i])
                return 1'b0;
        return !busy;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (!all_done() && t < 4000) begin
            step();
            t++;
        end
        check({tag, "_drain_timeout"}, 32'(t < 4000), 32'd1);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[15:0]));
        check({tag, "_trunc_cnt"}, 32'(trunc_cnt), 32'(exp_trunc > 255 ? 255 : exp_trunc));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_rden"}, 32'(bus.in_rden), 32'd0);
        check({tag, "_out"}, 32'({bus.out_wren, bus.out_eod, bus.out_din}), 32'd0);
        check({tag, "_cnts"}, 32'({frame_cnt, trunc_cnt}), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wr, bad_sp, prev_c, c, cnt, base;
        bit seen_zero, ok;

        ch_en         = '1;
        bus.out_afull = 1'b0;
        arst_n        = 1'b0;
        repeat (3) step();
        check_all_zero("reset");

        // ---- two 10-byte frames per channel, present at reset release ----
        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < N_CH; ch++)
                push_frame(ch, 10);
        grant_log.delete();
        arst_n = 1'b1;
        wait_drain("rr6");
        check("rr6_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("rr6_seq", 32'(grant_log[i]), 32'(i % N_CH));

        // ---- latency, 2-cycle byte spacing and inter-frame gap on ch0 ----
        push_frame(0, 14);
        push_frame(0, 5);
        base = int'(frame_cnt);
        @(negedge clk);
        @(negedge clk);
        check("lat_rden", 32'(bus.in_rden), 32'd1);
        @(negedge clk);
        check("lat_wren", 32'(bus.out_wren), 32'd1);
        n_wr = 0; bad_sp = 0; prev_c = 0; c = 0; ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (t > 0)
                @(negedge clk);
            c++;
            if (bus.out_wren) begin
                n_wr++;
                if (n_wr > 1 && c - prev_c != 2)
                    bad_sp++;
                prev_c = c;
                if (bus.out_eod)
                    ok = 1'b1;
            end
        end
        check("f14_eod_seen", 32'(ok), 32'd1);
        check("f14_writes", 32'(n_wr), 32'd14);
        check("f14_spacing", 32'(bad_sp), 32'd0);
        cnt = 0; seen_zero = 1'b0; ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1)
                check("frame_cnt_upd", 32'(frame_cnt), 32'(base + 1));
            if (grant == '0)
                seen_zero = 1'b1;
            else if (seen_zero)
                ok = 1'b1;
        end
        check("gap_regrant", 32'(ok), 32'd1);
        check("gap_cycles", 32'(cnt), 32'(IFG_CYC + 2));
        step();
        wait_drain("gap");

        // ---- truncation at MAX_LEN, exact-MAX_LEN frame, 1-byte frame ----
        push_frame(0, 20);
        push_frame(0, 8);
        push_frame(1, MAX_LEN);
        push_frame(2, 1);
        wait_drain("trunc");
        check("trunc_one", 32'(trunc_cnt), 32'd1);

        // ---- out_afull held for 20 cycles mid-frame on ch1 ----
        push_frame(1, 14);
        n_wr = 0;
        for (int t = 0; t < 200 && n_wr < 4; t++) begin
            @(negedge clk);
            if (bus.out_wren)
                n_wr++;
        end
        check("afull_prewrites", 32'(n_wr), 32'd4);
        step();
        bus.out_afull = 1'b1;
        n_wr = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.out_wren)
                n_wr++;
            check("afull_no_rden", 32'(bus.in_rden), 32'd0);
        end
        check("afull_max1_write", 32'(n_wr <= 1), 32'd1);
        step();
        bus.out_afull = 1'b0;
        wait_drain("afull");

        // ---- ch_en masking: ch1 never granted while disabled ----
        ch_en = 3'b101;
        for (int ch = 0; ch < N_CH; ch++) begin
            push_frame(ch, 6);
            push_frame(ch, 3);
        end
        grant_log.delete();
        c = 0;
        while ((exp_q[0].size() != 0 || exp_q[2].size() != 0 || busy) && c < 2000) begin
            step();
            c++;
        end
        check("mask_timeout", 32'(c < 2000), 32'd1);
        cnt = 0;
        foreach (grant_log[i])
            if (grant_log[i] == 1)
                cnt++;
        check("mask_ch1_grants", 32'(cnt), 32'd0);
        check("mask_ch1_pending", 32'(exp_q[1].size()), 32'd9);
        grant_log.delete();
        ch_en = 3'b111;
        wait_drain("mask");
        check("mask_ch1_served", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);

        // ---- randomized traffic with afull and enable churn ----
        for (int f = 0; f < 40; f++) begin
            push_frame(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(1, 24)));
            repeat ($urandom_range(0, 30)) begin
                step();
                if ($urandom_range(0, 9) == 0)
                    bus.out_afull = ~bus.out_afull;
                if ($urandom_range(0, 19) == 0)
                    ch_en = N_CH'($urandom);
            end
        end
        ch_en         = '1;
        bus.out_afull = 1'b0;
        wait_drain("random");

        // ---- reset mid-frame on ch2 ----
        push_frame(2, 14);
        n_wr = 0;
        for (int t = 0; t < 200 && n_wr < 3; t++) begin
            @(negedge clk);
            if (bus.out_wren)
                n_wr++;
        end
        check("rst_prewrites", 32'(n_wr), 32'd3);
        @(posedge clk);
        #1 arst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        exp_frames = 0;
        exp_trunc  = 0;
        @(negedge clk);
        step();
        for (int ch = 0; ch < N_CH; ch++)
            push_frame(ch, 6);
        grant_log.delete();
        arst_n = 1'b1;
        wait_drain("post_reset");
        check("post_reset_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
